pcie_io_mem_bridge: RTL and testbench

- Memory target sitting directly downstream of the PCIe IO endpoint's memory-request port.
- Accepts single-beat write/read requests (write bursts flagged by last), accesses an internal 64-bit-wide SRAM, and returns per-beat responses on the endpoint's response port.
- Expands each read request of N bytes into the required number of 64-bit response beats, flagging last.
- Flags fault for any out-of-range access.

---
 rtl/pcie_io_mem_bridge.sv | 132 +++++++++++++
 tb/tb_pcie_io_mem_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_io_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcie_io_mem_bridge: 64-bit SRAM target for the PCIe IO endpoint's memory |
// | request port; per-beat write acks and multi-beat read expansion.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pcie_io_mem_bridge #(
  parameter int MEM_ABITS = 12
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  output logic        o_req_mem_ready,
  input  logic        i_req_mem_valid,
  input  logic        i_req_mem_write,
  input  logic [9:0]  i_req_mem_bytes,
  input  logic [12:0] i_req_mem_addr,
  input  logic [7:0]  i_req_mem_strob,
  input  logic [63:0] i_req_mem_data,
  input  logic        i_req_mem_last,
  output logic        o_resp_mem_valid,
  output logic        o_resp_mem_last,
  output logic        o_resp_mem_fault,
  output logic [12:0] o_resp_mem_addr,
  output logic [63:0] o_resp_mem_data,
  input  logic        i_resp_mem_ready
);

  localparam int          WORDS    = 1 << (MEM_ABITS - 3);
  // Address bits above the implemented range; all-zero when MEM_ABITS is 13.
  localparam logic [12:0] OOR_MASK = 13'(~((32'd1 << MEM_ABITS) - 32'd1));

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t      state;
  logic [63:0] mem [WORDS];
  logic [12:0] rd_addr;
  logic [10:0] rd_nbeats;
  logic [10:0] rd_issued;

  logic        req_fire;
  logic        resp_fire;
  logic        wr_fire;
  logic        rd_start;
  logic        issue;
  logic        wr_oor;
  logic        beat_oor;
  logic [9:0]  beat_word;
  logic [12:0] beat_addr;
  logic [10:0] req_len;
  logic [10:0] req_nbeats;

  assign o_req_mem_ready = i_nrst & (state != READ) & (!o_resp_mem_valid | i_resp_mem_ready);

  assign req_fire  = i_req_mem_valid & o_req_mem_ready;
  assign resp_fire = o_resp_mem_valid & i_resp_mem_ready;
  // Inside a write burst every beat is a write regardless of the write flag.
  assign wr_fire   = req_fire & ((state == WRITE) | i_req_mem_write);
  assign rd_start  = req_fire & (state == IDLE) & !i_req_mem_write;
  assign issue     = (state == READ) & (rd_issued != rd_nbeats) &
                     (!o_resp_mem_valid | i_resp_mem_ready);

  assign beat_word  = rd_addr[12:3] + rd_issued[9:0];
  assign beat_addr  = (rd_issued == 11'd0) ? rd_addr : {beat_word, 3'b000};
  assign req_len    = (i_req_mem_bytes == 10'd0) ? 11'd1024 : {1'b0, i_req_mem_bytes};
  assign req_nbeats = (11'(i_req_mem_addr[2:0]) + req_len + 11'd7) >> 3;
  assign wr_oor     = |(i_req_mem_addr & OOR_MASK);
  assign beat_oor   = |(beat_addr & OOR_MASK);

  always_ff @(posedge i_clk) begin
    if (wr_fire && !wr_oor) begin
      for (int b = 0; b < 8; b++) begin
        if (i_req_mem_strob[b])
          mem[i_req_mem_addr[MEM_ABITS-1:3]][8*b +: 8] <= i_req_mem_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state            <= IDLE;
      rd_addr          <= '0;
      rd_nbeats        <= '0;
      rd_issued        <= '0;
      o_resp_mem_valid <= 1'b0;
      o_resp_mem_last  <= 1'b0;
      o_resp_mem_fault <= 1'b0;
      o_resp_mem_addr  <= '0;
      o_resp_mem_data  <= '0;
    end else begin
      if (issue) begin
        o_resp_mem_valid <= 1'b1;
        o_resp_mem_last  <= (rd_issued == rd_nbeats - 11'd1);
        o_resp_mem_fault <= beat_oor;
        o_resp_mem_addr  <= beat_addr;
        o_resp_mem_data  <= beat_oor ? 64'd0 : mem[beat_addr[MEM_ABITS-1:3]];
        rd_issued        <= rd_issued + 11'd1;
      end else if (wr_fire) begin
        o_resp_mem_valid <= 1'b1;
        o_resp_mem_last  <= i_req_mem_last;
        o_resp_mem_fault <= wr_oor;
        o_resp_mem_addr  <= i_req_mem_addr;
        o_resp_mem_data  <= 64'd0;
      end else if (resp_fire) begin
        o_resp_mem_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_fire) begin
            state <= i_req_mem_last ? IDLE : WRITE;
          end else if (rd_start) begin
            state     <= READ;
            rd_addr   <= i_req_mem_addr;
            rd_nbeats <= req_nbeats;
            rd_issued <= 11'd0;
          end
        end
        WRITE: begin
          if (wr_fire && i_req_mem_last)
            state <= IDLE;
        end
        READ: begin
          if (resp_fire && o_resp_mem_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcie_io_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pcie_io_mem_bridge: randomized bench with a byte-array reference model|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pcie_io_mem_bridge;

  localparam int MEM_ABITS = 12;
  localparam int MEM_BYTES = 1 << MEM_ABITS;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_ready;
  logic        req_valid;
  logic        req_write;
  logic [9:0]  req_bytes;
  logic [12:0] req_addr;
  logic [7:0]  req_strob;
  logic [63:0] req_data;
  logic        req_last;
  logic        resp_valid;
  logic        resp_last;
  logic        resp_fault;
  logic [12:0] resp_addr;
  logic [63:0] resp_data;
  logic        resp_ready;

  always #5 clk = ~clk;

  pcie_io_mem_bridge #(.MEM_ABITS(MEM_ABITS)) dut (
    .i_clk            (clk),
    .i_nrst           (nrst),
    .o_req_mem_ready  (req_ready),
    .i_req_mem_valid  (req_valid),
    .i_req_mem_write  (req_write),
    .i_req_mem_bytes  (req_bytes),
    .i_req_mem_addr   (req_addr),
    .i_req_mem_strob  (req_strob),
    .i_req_mem_data   (req_data),
    .i_req_mem_last   (req_last),
    .o_resp_mem_valid (resp_valid),
    .o_resp_mem_last  (resp_last),
    .o_resp_mem_fault (resp_fault),
    .o_resp_mem_addr  (resp_addr),
    .o_resp_mem_data  (resp_data),
    .i_resp_mem_ready (resp_ready)
  );

  typedef struct packed {
    logic        is_read;
    logic [12:0] addr;
    logic [63:0] data;
    logic        last;
    logic        fault;
  } beat_t;

  beat_t      expq[$];
  logic [7:0] mem_m [MEM_BYTES];
  logic       in_burst   = 1'b0;
  int         n_checks   = 0;
  int         n_errors   = 0;
  int         beats_seen = 0;
  int         rdy_mode   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_word(input int a);
    logic [63:0] w;
    int base;
    base = a - (a % 8);
    for (int b = 0; b < 8; b++) w[8*b +: 8] = mem_m[base + b];
    return w;
  endfunction

  // Reference behaviour: update byte memory / emit expected beats at accept time.
  task automatic model_accept(input logic w, input logic [9:0] bytes, input logic [12:0] addr,
                              input logic [7:0] strob, input logic [63:0] data, input logic last);
    beat_t e;
    int a, len, n, ba;
    a = int'(addr);
    if (w || in_burst) begin
      if (a < MEM_BYTES)
        for (int b = 0; b < 8; b++)
          if (strob[b]) mem_m[a - (a % 8) + b] = data[8*b +: 8];
      e = '{is_read: 1'b0, addr: addr, data: 64'd0, last: last, fault: (a >= MEM_BYTES)};
      expq.push_back(e);
      in_burst = !last;
    end else begin
      len = (bytes == 10'd0) ? 1024 : int'(bytes);
      n   = ((a % 8) + len + 7) / 8;
      for (int k = 0; k < n; k++) begin
        ba = (k == 0) ? a : ((((a / 8) + k) % 1024) * 8);
        e.is_read = 1'b1;
        e.addr    = 13'(ba);
        e.fault   = (ba >= MEM_BYTES);
        e.data    = e.fault ? 64'd0 : model_word(ba);
        e.last    = (k == n - 1);
        expq.push_back(e);
      end
    end
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input logic w, input logic [9:0] bytes, input logic [12:0] addr,
                        input logic [7:0] strob, input logic [63:0] data, input logic last);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_bytes = bytes;
    req_addr  = addr;
    req_strob = strob;
    req_data  = data;
    req_last  = last;
    for (int i = 0; i < 4000 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
    end
    if (acc) model_accept(w, bytes, addr, strob, data, last);
    else     check("req_accept_timeout", {63'd0, acc}, 64'd1);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && expq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_timeout", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {63'd0, req_ready},  64'd0);
    check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
    check({tag, "_resp_last"},  {63'd0, resp_last},  64'd0);
    check({tag, "_resp_fault"}, {63'd0, resp_fault}, 64'd0);
    check({tag, "_resp_addr"},  64'(resp_addr),      64'd0);
    check({tag, "_resp_data"},  resp_data,           64'd0);
  endtask

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = ~resp_ready;
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Response monitor: scoreboard compare, hold-stability, and request blocking during reads.
  initial begin
    beat_t       e;
    logic        prev_stall;
    logic        p_last, p_fault;
    logic [12:0] p_addr;
    logic [63:0] p_data;
    prev_stall = 1'b0;
    p_last = 1'b0; p_fault = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      if (nrst) begin
        if (prev_stall) begin
          check("hold_valid", {63'd0, resp_valid}, 64'd1);
          check("hold_addr",  64'(resp_addr),      64'(p_addr));
          check("hold_data",  resp_data,           p_data);
          check("hold_last",  {63'd0, resp_last},  {63'd0, p_last});
          check("hold_fault", {63'd0, resp_fault}, {63'd0, p_fault});
        end
        if (expq.size() != 0 && expq[0].is_read)
          check("req_ready_during_read", {63'd0, req_ready}, 64'd0);
        if (resp_valid && resp_ready) begin
          if (expq.size() == 0) begin
            check("spurious_beat", {63'd0, resp_valid}, 64'd0);
          end else begin
            e = expq.pop_front();
            check("beat_addr",  64'(resp_addr),      64'(e.addr));
            check("beat_data",  resp_data,           e.data);
            check("beat_last",  {63'd0, resp_last},  {63'd0, e.last});
            check("beat_fault", {63'd0, resp_fault}, {63'd0, e.fault});
            beats_seen++;
          end
        end
        prev_stall = resp_valid && !resp_ready;
        p_last = resp_last; p_fault = resp_fault; p_addr = resp_addr; p_data = resp_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, cyc;
    logic [12:0] a;
    logic [63:0] d;
    nrst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_bytes = '0; req_addr = '0;
    req_strob = '0;   req_data = '0;    req_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < MEM_BYTES / 8; i++)
      do_req(1'b1, 10'd0, 13'(i * 8), 8'hFF, {$urandom, $urandom}, (i == MEM_BYTES / 8 - 1));
    wait_drain();

    do_req(1'b1, 10'd0, 13'h010, 8'hFF, 64'h1122334455667788, 1'b1);
    @(negedge clk);
    check("write_latency", {63'd0, resp_valid}, 64'd1);
    @(posedge clk);
    #1;
    do_req(1'b0, 10'd8, 13'h010, 8'h00, 64'd0, 1'b0);

    do_req(1'b1, 10'd0, 13'h020, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    do_req(1'b1, 10'd0, 13'h020, 8'h0F, 64'd0, 1'b1);
    do_req(1'b0, 10'd8, 13'h020, 8'h00, 64'd0, 1'b0);

    do_req(1'b0, 10'd16, 13'h004, 8'h00, 64'd0, 1'b0);

    do_req(1'b1, 10'd0, 13'h040, 8'hA5, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
    do_req(1'b0, 10'd8, 13'h040, 8'h00, 64'd0, 1'b0);
    wait_drain();

    s = beats_seen;
    do_req(1'b0, 10'd64, 13'h000, 8'h00, 64'd0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen > s) cyc++;
      if (beats_seen >= s + 8) break;
    end
    check("read_throughput_cycles", 64'(cyc), 64'd8);
    wait_drain();

    rdy_mode = 1;
    do_req(1'b0, 10'd0, 13'h000, 8'h00, 64'd0, 1'b0);
    wait_drain();
    rdy_mode = 0;

    do_req(1'b1, 10'd0, 13'h1000, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1);
    do_req(1'b0, 10'd8, 13'h1000, 8'h00, 64'd0, 1'b0);
    do_req(1'b0, 10'd16, 13'h0FF8, 8'h00, 64'd0, 1'b0);
    do_req(1'b0, 10'd8, 13'h0000, 8'h00, 64'd0, 1'b0);
    wait_drain();

    rdy_mode = 2;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        s = $urandom_range(1, 4);
        for (int j = 0; j < s; j++) begin
          a = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, MEM_BYTES - 1));
          d = {$urandom, $urandom};
          do_req((j == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 10'($urandom), a,
                 8'($urandom), d, (j == s - 1));
        end
      end else begin
        a = ($urandom_range(0, 7) == 0) ? 13'($urandom) : 13'($urandom_range(0, MEM_BYTES - 1));
        if ($urandom_range(0, 9) == 0)
          do_req(1'b0, 10'($urandom), a, 8'($urandom), 64'd0, 1'b0);
        else
          do_req(1'b0, 10'($urandom_range(1, 40)), a, 8'($urandom), 64'd0, 1'b0);
      end
    end
    wait_drain();

    rdy_mode = 0;
    @(posedge clk);
    #1;
    s = beats_seen;
    do_req(1'b0, 10'd32, 13'h000, 8'h00, 64'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen >= s + 2) break;
    end
    check("beats_before_reset", 64'(beats_seen - s), 64'd2);
    #1;
    nrst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    expq.delete();
    in_burst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_beat", {63'd0, resp_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    do_req(1'b1, 10'd0, 13'h018, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b1);
    do_req(1'b0, 10'd8, 13'h018, 8'h00, 64'd0, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
